// File: rtl/nvdla_sdp_unpack_pkg.sv
// Shared types and helpers for the SDP RDMA wide-to-narrow unpacker.
package nvdla_sdp_unpack_pkg;

    typedef enum logic [1:0] {
        SEG_FULL    = 2'd0,
        SEG_HALF    = 2'd1,
        SEG_QUARTER = 2'd2,
        SEG_ONE     = 2'd3
    } seg_mode_e;

    localparam int UNPACK_IW = 512;
    localparam int UNPACK_OW = 128;
    localparam int UNPACK_CW = 1;

    // Segments per beat for a given mode; never less than one.
    function automatic int cfg_count(input int maxr, input seg_mode_e mode);
        int c;
        c = (mode == SEG_ONE) ? 1 : (maxr >> int'(mode));
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/nvdla_sdp_unpack_skid.sv
// Two-entry output slice: registered valid/data and a ready that depends only on local state.
module nvdla_sdp_unpack_skid #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_data_o,
    output logic         empty_o
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         push, pop;

    assign in_rdy_o   = (cnt_q != 2'd2);
    assign out_vld_o  = (cnt_q != 2'd0);
    assign out_data_o = slot0_q;
    assign empty_o    = (cnt_q == 2'd0);

    assign push = in_vld_i & in_rdy_o;
    assign pop  = out_vld_o & out_rdy_i;

    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) slot0_d = in_data_i;
                else               slot1_d = in_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop keeps occupancy; the head always advances.
                if (cnt_q == 2'd1) begin
                    slot0_d = in_data_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

endmodule

// File: rtl/nvdla_sdp_rdma_unpack.sv
// SDP RDMA return-path unpacker: splits each IW-bit beat into up to MAXR OW-bit segments, LSB first.
// Optional registered output slice enabled by defining NVDLA_SDP_UNPACK_OUTREG_EN.
module nvdla_sdp_rdma_unpack
    import nvdla_sdp_unpack_pkg::*;
#(
    parameter int IW   = UNPACK_IW,
    parameter int OW   = UNPACK_OW,
    parameter int CW   = UNPACK_CW,
    parameter int MAXR = IW / OW,
    parameter int SW   = $clog2(MAXR) + 1
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic [1:0]    cfg_seg_mode,
    input  logic          inp_pvld,
    output logic          inp_prdy,
    input  logic [IW-1:0] inp_data,
    input  logic [CW-1:0] inp_ctrl,
    input  logic [SW-1:0] inp_nseg,
    output logic          out_pvld,
    input  logic          out_prdy,
    output logic [OW-1:0] out_data,
    output logic [CW-1:0] out_ctrl,
    output logic          out_last,
    output logic [SW-2:0] out_idx,
    output logic          idle
);

    localparam int IXW = SW - 1;

    logic          hold_vld_q, hold_vld_d;
    logic [IW-1:0] hold_data_q, hold_data_d;
    logic [CW-1:0] hold_ctrl_q, hold_ctrl_d;
    logic [SW-1:0] hold_n_q, hold_n_d;
    logic [IXW-1:0] seg_cnt_q, seg_cnt_d;

    logic [SW-1:0] cfg_cnt, eff_n;
    logic          inp_acc, mux_rdy, mux_acc, mux_last;
    logic [OW-1:0] mux_data;
    logic [CW-1:0] mux_ctrl;

    assign cfg_cnt = SW'(cfg_count(MAXR, seg_mode_e'(cfg_seg_mode)));
    // Zero or oversized partial counts fall back to the mode count.
    assign eff_n   = (inp_nseg != '0 && inp_nseg < cfg_cnt) ? inp_nseg : cfg_cnt;

    assign mux_data = hold_data_q[int'(seg_cnt_q) * OW +: OW];
    assign mux_last = hold_vld_q & (({1'b0, seg_cnt_q} + SW'(1)) == hold_n_q);
    assign mux_ctrl = hold_ctrl_q & {CW{mux_last}};
    assign mux_acc  = hold_vld_q & mux_rdy;

    assign inp_prdy = !hold_vld_q | (mux_acc & mux_last);
    assign inp_acc  = inp_pvld & inp_prdy;

    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        hold_ctrl_d = hold_ctrl_q;
        hold_n_d    = hold_n_q;
        seg_cnt_d   = seg_cnt_q;
        if (mux_acc) begin
            if (mux_last) begin
                hold_vld_d = 1'b0;
                seg_cnt_d  = '0;
            end else begin
                seg_cnt_d = seg_cnt_q + 1'b1;
            end
        end
        // A new beat may load in the same cycle the previous one retires.
        if (inp_acc) begin
            hold_vld_d  = 1'b1;
            hold_data_d = inp_data;
            hold_ctrl_d = inp_ctrl;
            hold_n_d    = eff_n;
            seg_cnt_d   = '0;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            hold_ctrl_q <= '0;
            hold_n_q    <= '0;
            seg_cnt_q   <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            hold_ctrl_q <= hold_ctrl_d;
            hold_n_q    <= hold_n_d;
            seg_cnt_q   <= seg_cnt_d;
        end
    end

`ifdef NVDLA_SDP_UNPACK_OUTREG_EN
    logic                  skid_empty;
    logic [OW+CW+SW-1:0]   skid_out;

    nvdla_sdp_unpack_skid #(
        .W(OW + CW + SW)
    ) u_skid (
        .clk_i      (nvdla_core_clk),
        .rst_i      (nvdla_core_rst),
        .in_vld_i   (hold_vld_q),
        .in_rdy_o   (mux_rdy),
        .in_data_i  ({mux_ctrl, mux_last, seg_cnt_q, mux_data}),
        .out_vld_o  (out_pvld),
        .out_rdy_i  (out_prdy),
        .out_data_o (skid_out),
        .empty_o    (skid_empty)
    );

    assign {out_ctrl, out_last, out_idx, out_data} = skid_out;
    assign idle = !hold_vld_q && skid_empty;
`else
    assign mux_rdy  = out_prdy;
    assign out_pvld = hold_vld_q;
    assign out_data = mux_data;
    assign out_ctrl = mux_ctrl;
    assign out_last = mux_last;
    assign out_idx  = seg_cnt_q;
    assign idle     = !hold_vld_q;
`endif

endmodule

// File: tb/tb_nvdla_sdp_rdma_unpack.sv
// Scoreboard bench for nvdla_sdp_rdma_unpack (IW=512, OW=128, MAXR=4, CW=1).
module tb_nvdla_sdp_rdma_unpack;

    localparam int IW = 512;
    localparam int OW = 128;
    localparam int CW = 1;
    localparam int MAXR = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg_seg_mode = 2'd0;
    logic          inp_pvld = 1'b0;
    logic          inp_prdy;
    logic [IW-1:0] inp_data = '0;
    logic [CW-1:0] inp_ctrl = '0;
    logic [SW-1:0] inp_nseg = '0;
    logic          out_pvld;
    logic          out_prdy;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_last;
    logic [SW-2:0] out_idx;
    logic          idle;

    logic prdy_dir = 1'b0;
    logic prdy_rand = 1'b0;
    logic rand_en = 1'b0;
    assign out_prdy = rand_en ? prdy_rand : prdy_dir;

    always #5 clk = ~clk;

    nvdla_sdp_rdma_unpack #(.IW(IW), .OW(OW), .CW(CW), .MAXR(MAXR), .SW(SW)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_seg_mode   (cfg_seg_mode),
        .inp_pvld       (inp_pvld),
        .inp_prdy       (inp_prdy),
        .inp_data       (inp_data),
        .inp_ctrl       (inp_ctrl),
        .inp_nseg       (inp_nseg),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_data       (out_data),
        .out_ctrl       (out_ctrl),
        .out_last       (out_last),
        .out_idx        (out_idx),
        .idle           (idle)
    );

    typedef struct {
        logic [OW-1:0] data;
        logic          ctrl;
        logic          last;
        logic [1:0]    idx;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1 prdy_rand = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks stall stability.
    initial begin
        logic          stall;
        logic [OW-1:0] s_data;
        logic          s_ctrl, s_last;
        logic [1:0]    s_idx;
        exp_t          e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall)
                    chk("stall_stable", {out_pvld, out_data, out_ctrl, out_last, out_idx},
                        {1'b1, s_data, s_ctrl, s_last, s_idx});
                stall  = out_pvld && !out_prdy;
                s_data = out_data;
                s_ctrl = out_ctrl;
                s_last = out_last;
                s_idx  = out_idx;
                if (out_pvld && out_prdy) begin
                    acc_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_seg: got data %h idx %0d want none", out_data, out_idx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("seg_data", 160'(out_data), 160'(e.data));
                        chk("seg_ctrl", 160'(out_ctrl), 160'(e.ctrl));
                        chk("seg_last", 160'(out_last), 160'(e.last));
                        chk("seg_idx",  160'(out_idx),  160'(e.idx));
                    end
                end
`ifndef NVDLA_SDP_UNPACK_OUTREG_EN
                if (out_pvld && !(out_prdy && out_last))
                    chk("inp_prdy_blocked", 160'(inp_prdy), 160'(0));
`endif
            end
        end
    end

    task automatic send(input logic [IW-1:0] d, input logic c, input logic [2:0] ns, input int exp_n);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        inp_data = d;
        inp_ctrl = c;
        inp_nseg = ns;
        inp_pvld = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = inp_prdy;
            @(posedge clk);
        end
        if (!ok) begin
            flag_fail("send_accept");
        end else begin
            for (int k = 0; k < exp_n; k++) begin
                e.data = d[k*OW +: OW];
                e.last = (k == exp_n - 1);
                e.ctrl = e.last ? c : 1'b0;
                e.idx  = 2'(k);
                exp_q.push_back(e);
            end
        end
        #1;
        inp_pvld = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && idle;
        end
        if (!done) begin
            flag_fail("drain");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_vld();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = out_pvld;
        end
        if (!seen) flag_fail("wait_out_pvld");
        @(posedge clk);
        #1;
    endtask

    localparam logic [OW-1:0] WA = 128'h0A0A_0A0A_1111_2222_3333_4444_5555_000A;
    localparam logic [OW-1:0] WB = 128'h0B0B_0B0B_6666_7777_8888_9999_AAAA_000B;
    localparam logic [OW-1:0] WC = 128'h0C0C_0C0C_BBBB_CCCC_DDDD_EEEE_FFFF_000C;
    localparam logic [OW-1:0] WD = 128'h0D0D_0D0D_1234_5678_9ABC_DEF0_0F0F_000D;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_pvld", 160'(out_pvld), 160'(0));
        chk("rst_out_data", 160'(out_data), 160'(0));
        chk("rst_out_ctrl", 160'(out_ctrl), 160'(0));
        chk("rst_out_last", 160'(out_last), 160'(0));
        chk("rst_out_idx",  160'(out_idx),  160'(0));
        chk("rst_inp_prdy", 160'(inp_prdy), 160'(1));
        chk("rst_idle",     160'(idle),     160'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        prdy_dir = 1'b1;

        // Full beat, ctrl only on the last segment.
        cfg_seg_mode = 2'd0;
        send({WD, WC, WB, WA}, 1'b1, 3'd0, 4);
        drain();

        // Half mode, back-to-back beats without a bubble.
        cfg_seg_mode = 2'd1;
        acc_cyc.delete();
        send({WA, WA, WB, WC}, 1'b1, 3'd0, 2);
        send({WB, WB, WD, WA}, 1'b0, 3'd0, 2);
        drain();
        chk("no_bubble_count", 160'(acc_cyc.size()), 160'(4));
        if (acc_cyc.size() == 4)
            chk("no_bubble_span", 160'(acc_cyc[3] - acc_cyc[0]), 160'(3));

        // Partial counts: 3 honoured, 7 clamped to the mode count.
        cfg_seg_mode = 2'd0;
        send({WA, WD, WC, WB}, 1'b1, 3'd3, 3);
        send({WC, WB, WA, WD}, 1'b0, 3'd7, 4);
        drain();

        // Random output backpressure.
        rand_en = 1'b1;
        send({WB, WC, WD, WA}, 1'b1, 3'd0, 4);
        send({WD, WA, WB, WC}, 1'b1, 3'd2, 2);
        send({WC, WD, WA, WB}, 1'b0, 3'd0, 4);
        send({WA, WB, WC, WD}, 1'b1, 3'd1, 1);
        drain();
        rand_en = 1'b0;

        // Mode change while a beat is held at idx1.
        prdy_dir = 1'b0;
        cfg_seg_mode = 2'd0;
        send({WD, WC, WB, WA}, 1'b1, 3'd0, 4);
        wait_out_vld();
        prdy_dir = 1'b1;
        @(posedge clk);
        #1;
        prdy_dir = 1'b0;
        @(negedge clk);
        chk("held_idx1", 160'({out_pvld, out_idx}), 160'({1'b1, 2'd1}));
        @(posedge clk);
        #1;
        cfg_seg_mode = 2'd2;
        prdy_dir = 1'b1;
        send({WA, WB, WC, WD}, 1'b1, 3'd0, 1);
        drain();

        // Reset while held at idx2 discards the beat.
        cfg_seg_mode = 2'd0;
        prdy_dir = 1'b0;
        send({WB, WA, WD, WC}, 1'b1, 3'd0, 4);
        wait_out_vld();
        prdy_dir = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        prdy_dir = 1'b0;
        @(negedge clk);
        chk("pre_rst_idx2", 160'({out_pvld, out_idx}), 160'({1'b1, 2'd2}));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_out_pvld", 160'(out_pvld), 160'(0));
        chk("post_rst_idle",     160'(idle),     160'(1));
        chk("post_rst_inp_prdy", 160'(inp_prdy), 160'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        prdy_dir = 1'b1;
        send({WC, WD, WB, WA}, 1'b1, 3'd0, 4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
